acia_tx_arbiter: RTL and testbench

- Shares the single ACIA/UART transmit path between two byte-stream sources: source 0 is the CPU console path, source 1 is the hardware debug monitor.
- Arbitrates at message granularity. A grant is locked until that source's last byte, a burst cap, or an idle timeout.
- Round-robin between sources for fairness.
- Sits between the sources and the UART write port (wr_uart, w_data, tx_full), so messages from the two sources never interleave on the serial line.

---
 rtl/acia_pkg.sv | 11 +
 rtl/acia_tx_arbiter.sv | 72 +++++++
 tb/tb_acia_tx_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/acia_pkg.sv
// acia_pkg: shared types and defaults for the ACIA transmit arbiter
// state_t: IDLE / OWN0 / OWN1 arbiter states
// GNT_*: one-hot grant encodings; DEF_*: default MAX_BURST / IDLE_TIMEOUT values
package acia_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_S0 = 2'b01;
  localparam logic [1:0] GNT_S1 = 2'b10;
  localparam int DEF_MAX_BURST = 64;
  localparam int DEF_IDLE_TIMEOUT = 16;
endpackage

// File: rtl/acia_tx_arbiter.sv
// acia_tx_arbiter: message-granular round-robin sharing of one UART write port between two byte sources
// clk, rst: clock and synchronous active-high reset
// s0_valid/s0_data/s0_last/s0_ready: CPU console byte stream
// s1_valid/s1_data/s1_last/s1_ready: debug monitor byte stream
// tx_full, wr_uart, w_data: UART transmit FIFO write port
// grant: one-hot current owner (00 = none); busy: a grant is active
import acia_pkg::*;

module acia_tx_arbiter #(
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic [1:0] grant,
  output logic       busy
);
  state_t state;
  logic prio;
  logic [7:0] bcnt;
  logic [15:0] icnt;
  logic own0, own1, ovalid, olast, rel;

  // Both valid: prio decides; otherwise the lone requester wins.
  function automatic state_t pick(input logic v0, input logic v1, input logic p);
    return (v0 && v1) ? (p ? OWN1 : OWN0) : v0 ? OWN0 : v1 ? OWN1 : IDLE;
  endfunction

  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign grant = own0 ? GNT_S0 : own1 ? GNT_S1 : GNT_NONE;
  assign busy = own0 || own1;
  assign s0_ready = own0 && !tx_full;
  assign s1_ready = own1 && !tx_full;
  assign ovalid = own0 ? s0_valid : own1 && s1_valid;
  assign olast = own0 ? s0_last : own1 && s1_last;
  assign wr_uart = (s0_valid && s0_ready) || (s1_valid && s1_ready);
  assign w_data = own0 ? s0_data : own1 ? s1_data : 8'h00;
  // Stalls on tx_full keep valid high, so they never feed the idle timeout.
  assign rel = busy && ((wr_uart && (olast || ({1'b0, bcnt} + 9'd1 == 9'(MAX_BURST))))
             || (IDLE_TIMEOUT != 0 && !ovalid && icnt == 16'(IDLE_TIMEOUT - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      bcnt <= '0;
      icnt <= '0;
    end else if (!busy) begin
      state <= pick(s0_valid, s1_valid, prio);
    end else if (rel) begin
      prio <= own0;
      bcnt <= '0;
      icnt <= '0;
      state <= pick(s0_valid, s1_valid, own0);
    end else begin
      bcnt <= bcnt + 8'(wr_uart);
      icnt <= ovalid ? '0 : icnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_acia_tx_arbiter.sv
// tb_acia_tx_arbiter: scoreboard bench for acia_tx_arbiter (MAX_BURST=4, IDLE_TIMEOUT=4)
module tb_acia_tx_arbiter;
  logic clk = 0, rst = 1, tx_full = 0;
  logic s0_valid = 0, s0_last = 0, s1_valid = 0, s1_last = 0;
  logic [7:0] s0_data = 0, s1_data = 0;
  logic s0_ready, s1_ready, wr_uart, busy;
  logic [7:0] w_data;
  logic [1:0] grant;
  int tests = 0, fails = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  acia_tx_arbiter #(.MAX_BURST(4), .IDLE_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .grant(grant), .busy(busy)
  );

  task automatic drive(input int src, input logic v, input logic [7:0] d, input logic l);
    if (src == 0) begin
      s0_valid = v; s0_data = d; s0_last = l;
    end else begin
      s1_valid = v; s1_data = d; s1_last = l;
    end
  endtask

  task automatic send(input int src, input logic [7:0] first, input int n, input logic fin);
    for (int i = 0; i < n; i++) begin
      logic acc;
      int c;
      acc = 0;
      c = 0;
      drive(src, 1'b1, first + 8'(i), fin && i == n - 1);
      while (!acc && c < 200) begin
        @(negedge clk);
        acc = src == 0 ? s0_ready : s1_ready;
        @(posedge clk); #1;
        c++;
      end
      tests++;
      if (!acc) begin
        fails++;
        $display("FAIL send%0d: byte %h not accepted within 200 cycles", src, first + 8'(i));
      end
    end
    drive(src, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic settle;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d bytes never written, required 0", sb.size());
    end
  endtask

  task automatic test_reset;
    rst = 1; s0_valid = 1; s0_data = 8'h77;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL rst_grant: got %b required 00", grant); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
    tests++; if (wr_uart !== 1'b0) begin fails++; $display("FAIL rst_wr: got %b required 0", wr_uart); end
    tests++; if (w_data !== 8'h00) begin fails++; $display("FAIL rst_wdata: got %h required 00", w_data); end
    tests++; if (s0_ready !== 1'b0) begin fails++; $display("FAIL rst_s0_ready: got %b required 0", s0_ready); end
    tests++; if (s1_ready !== 1'b0) begin fails++; $display("FAIL rst_s1_ready: got %b required 0", s1_ready); end
    @(posedge clk); #1;
    rst = 0; s0_valid = 0; s0_data = 0;
  endtask

  task automatic test_single;
    for (int i = 0; i < 3; i++) sb.push_back({2'b01, 8'h41 + 8'(i)});
    fork
      send(0, 8'h41, 3, 1'b1);
      begin
        @(negedge clk);
        tests++;
        if (grant !== 2'b00 || wr_uart !== 1'b0) begin
          fails++; $display("FAIL single_first: grant %b wr %b, required 00 0", grant, wr_uart);
        end
        @(negedge clk);
        tests++;
        if (grant !== 2'b01 || wr_uart !== 1'b1) begin
          fails++; $display("FAIL single_grant: grant %b wr %b, required 01 1", grant, wr_uart);
        end
      end
    join
    repeat (5) @(negedge clk);
    tests++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      fails++; $display("FAIL single_release: grant %b busy %b, required 00 0", grant, busy);
    end
    settle;
  endtask

  task automatic test_contention;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    sb.push_back({2'b01, 8'h10}); sb.push_back({2'b01, 8'h11});
    sb.push_back({2'b10, 8'h20}); sb.push_back({2'b10, 8'h21});
    fork
      send(0, 8'h10, 2, 1'b1);
      send(1, 8'h20, 2, 1'b1);
      begin
        int n;
        n = 0;
        while (!(wr_uart === 1'b1 && w_data === 8'h11) && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        tests++;
        if (grant !== 2'b10 || wr_uart !== 1'b1 || w_data !== 8'h20) begin
          fails++; $display("FAIL handoff: grant %b wr %b data %h, required 10 1 20", grant, wr_uart, w_data);
        end
      end
    join
    settle;
    sb.push_back({2'b01, 8'h30}); sb.push_back({2'b10, 8'h31});
    fork
      send(0, 8'h30, 1, 1'b1);
      send(1, 8'h31, 1, 1'b1);
    join
    settle;
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 6; i++) sb.push_back({2'b10, 8'ha0 + 8'(i)});
    fork
      send(1, 8'ha0, 6, 1'b1);
      begin
        int n, k;
        n = 0; k = 0;
        while (k < 2 && n < 50) begin
          @(negedge clk);
          n++;
          if (wr_uart === 1'b1) k++;
        end
        @(posedge clk); #1;
        tx_full = 1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          tests++;
          if (s1_ready !== 1'b0 || wr_uart !== 1'b0 || grant !== 2'b10) begin
            fails++;
            $display("FAIL stall%0d: ready %b wr %b grant %b, required 0 0 10", i, s1_ready, wr_uart, grant);
          end
        end
        @(posedge clk); #1;
        tx_full = 0;
      end
    join
    settle;
  endtask

  task automatic test_burst;
    for (int i = 0; i < 4; i++) sb.push_back({2'b01, 8'hb0 + 8'(i)});
    sb.push_back({2'b10, 8'hc0});
    for (int i = 4; i < 10; i++) sb.push_back({2'b01, 8'hb0 + 8'(i)});
    fork
      send(0, 8'hb0, 10, 1'b0);
      send(1, 8'hc0, 1, 1'b1);
    join
    settle;
  endtask

  task automatic test_timeout;
    sb.push_back({2'b01, 8'hd0}); sb.push_back({2'b10, 8'he0});
    send(0, 8'hd0, 1, 1'b0);
    fork
      send(1, 8'he0, 1, 1'b1);
      for (int i = 0; i < 5; i++) begin
        logic [1:0] exp_g;
        exp_g = i < 4 ? 2'b01 : 2'b10;
        @(negedge clk);
        tests++;
        if (grant !== exp_g) begin
          fails++; $display("FAIL timeout_c%0d: grant %b required %b", i, grant, exp_g);
        end
      end
    join
    settle;
  endtask

  task automatic test_reset_mid;
    sb.push_back({2'b01, 8'h5a});
    send(0, 8'h5a, 1, 1'b1);
    sb.push_back({2'b10, 8'hf0}); sb.push_back({2'b10, 8'hf1});
    send(1, 8'hf0, 2, 1'b0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    sb.push_back({2'b01, 8'h55}); sb.push_back({2'b10, 8'hf2});
    fork
      send(0, 8'h55, 1, 1'b1);
      send(1, 8'hf2, 1, 1'b1);
      begin
        @(negedge clk);
        tests++;
        if (grant !== 2'b00 || busy !== 1'b0 || wr_uart !== 1'b0) begin
          fails++; $display("FAIL midrst: grant %b busy %b wr %b, required 00 0 0", grant, busy, wr_uart);
        end
      end
    join
    settle;
  endtask

  initial begin
    fork
      forever begin
        logic [9:0] e;
        @(negedge clk);
        if (wr_uart === 1'b1) begin
          tests++;
          if (sb.size() == 0) begin
            fails++; $display("FAIL uart_write: got byte %h grant %b, required no write", w_data, grant);
          end else begin
            e = sb.pop_front();
            if ({grant, w_data} !== e) begin
              fails++;
              $display("FAIL uart_write: got grant %b byte %h, required grant %b byte %h", grant, w_data, e[9:8], e[7:0]);
            end
          end
        end
      end
    join_none
    test_reset;
    test_single;
    test_contention;
    test_backpressure;
    test_burst;
    test_timeout;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
